// File: rtl/mips_mc_control.sv
// Multicycle MIPS main controller: per-phase ALU code, operand selects and
// datapath/memory strobes, with branch resolution on Zero and memory handshake stalls.
module mips_mc_control #(
    parameter int unsigned FETCH_ADD_CONST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic [3:0] alu_control,
    output logic [1:0] alu_srcA_sel,
    output logic [1:0] alu_srcB_sel,
    output logic       ext_zero,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_instr,
    output logic       instr_done
);

    // The datapath supplies the PC increment on srcB=01; only a value of 4 is wired there.
    if (FETCH_ADD_CONST != 4) begin : g_bad_fetch_const
        $error("mips_mc_control: FETCH_ADD_CONST must be 4");
    end

    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_ROR = 4'b1110;
    localparam logic [3:0] ALU_ROL = 4'b1101;
    localparam logic [3:0] ALU_SLT = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1011;
    localparam logic [3:0] ALU_XOR = 4'b1111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_RTYPE_WB, S_EXEC_I, S_ITYPE_WB, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    logic       r_shift;
    logic       mem_read_c, mem_write_c, ir_write_c, pc_write_c;
    logic       reg_write_c, illegal_c, done_c;

    function automatic logic r_legal(input logic [5:0] f);
        case (f)
            6'b000000, 6'b000010, 6'b000011, 6'b000110, 6'b000111,
            6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
            6'b100101, 6'b100110, 6'b100111, 6'b101010: r_legal = 1'b1;
            default:                                      r_legal = 1'b0;
        endcase
    endfunction

    // Returns {is_shift, alu code}; shifts take their A operand from shamt.
    function automatic logic [4:0] r_op(input logic [5:0] f);
        case (f)
            6'b000000: r_op = {1'b1, ALU_SLL};
            6'b000010: r_op = {1'b1, ALU_SRL};
            6'b000011: r_op = {1'b1, ALU_SRA};
            6'b000110: r_op = {1'b1, ALU_ROR};
            6'b000111: r_op = {1'b1, ALU_ROL};
            6'b100010, 6'b100011: r_op = {1'b0, ALU_SUB};
            6'b100100: r_op = {1'b0, ALU_AND};
            6'b100101: r_op = {1'b0, ALU_OR};
            6'b100110: r_op = {1'b0, ALU_XOR};
            6'b100111: r_op = {1'b0, ALU_NOR};
            6'b101010: r_op = {1'b0, ALU_SLT};
            default:   r_op = {1'b0, ALU_ADD};
        endcase
    endfunction

    function automatic logic [3:0] i_alu(input logic [5:0] op);
        case (op)
            6'b001010: i_alu = ALU_SLT;
            6'b001100: i_alu = ALU_AND;
            6'b001101: i_alu = ALU_OR;
            6'b001110: i_alu = ALU_XOR;
            default:   i_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        funct_d      = funct_q;
        r_shift      = 1'b0;
        alu_control  = ALU_ADD;
        alu_srcA_sel = '0;
        alu_srcB_sel = '0;
        ext_zero     = 1'b0;
        iord         = 1'b0;
        pc_src       = '0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        illegal_c    = 1'b0;
        done_c       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read_c   = 1'b1;
                alu_srcB_sel = 2'b01;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d         = opcode;
                funct_d      = funct;
                alu_srcB_sel = 2'b11;
                case (opcode)
                    6'b000000:            state_d = r_legal(funct) ? S_EXEC_R : S_ILLEGAL;
                    6'b100011, 6'b101011: state_d = S_MEM_ADDR;
                    6'b000100, 6'b000101: state_d = S_BRANCH;
                    6'b000010:            state_d = S_JUMP;
                    6'b001000, 6'b001001, 6'b001010,
                    6'b001100, 6'b001101, 6'b001110: state_d = S_EXEC_I;
                    default:              state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                {r_shift, alu_control} = r_op(funct_q);
                alu_srcA_sel = r_shift ? 2'b10 : 2'b01;
                state_d      = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                reg_write_c = 1'b1;
                reg_dst     = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXEC_I: begin
                alu_control  = i_alu(op_q);
                alu_srcA_sel = 2'b01;
                alu_srcB_sel = 2'b10;
                ext_zero     = (op_q == 6'b001100) || (op_q == 6'b001101) || (op_q == 6'b001110);
                state_d      = S_ITYPE_WB;
            end
            S_ITYPE_WB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_srcA_sel = 2'b01;
                alu_srcB_sel = 2'b10;
                state_d      = (op_q == 6'b100011) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                iord       = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                iord        = 1'b1;
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_control  = ALU_SUB;
                alu_srcA_sel = 2'b01;
                pc_src       = 2'b01;
                pc_write_c   = op_q[0] ? ~Zero : Zero;
                done_c       = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write_c = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State sits in FETCH during reset, so strobes are masked by rst_n directly.
    assign mem_read      = mem_read_c  & rst_n;
    assign mem_write     = mem_write_c & rst_n;
    assign ir_write      = ir_write_c  & rst_n;
    assign pc_write      = pc_write_c  & rst_n;
    assign reg_write     = reg_write_c & rst_n;
    assign illegal_instr = illegal_c   & rst_n;
    assign instr_done    = done_c      & rst_n;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: a driver pushes per-instruction expectations
// from an instruction-level model; a monitor summarises each retired instruction and compares.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic [3:0] alu_control;
    logic [1:0] alu_srcA_sel, alu_srcB_sel, pc_src;
    logic       ext_zero, iord, mem_read, mem_write, ir_write, pc_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal_instr, instr_done;

    mips_mc_control #(.FETCH_ADD_CONST(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero),
        .mem_ready(mem_ready), .alu_control(alu_control), .alu_srcA_sel(alu_srcA_sel),
        .alu_srcB_sel(alu_srcB_sel), .ext_zero(ext_zero), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_ILL} kind_t;

    // Instruction-level summary of one instruction as seen at the controller outputs.
    typedef struct {
        int kind;
        int total;
        int alu2, srca2, srcb2, ext2, pcsrc2;
        int pcw, regw, rdst, m2r, memr, memw, iordc, irw, done, ill;
    } summ_t;

    summ_t sb[$];
    string sb_nm[$];

    int r_f  [14] = '{0, 2, 3, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42};
    int r_c  [14] = '{8, 9, 10, 14, 13, 2, 2, 6, 6, 3, 7, 15, 11, 1};
    int i_op [6]  = '{8, 9, 10, 12, 13, 14};
    int i_c  [6]  = '{2, 2, 1, 3, 7, 15};

    function automatic void classify(input int op, input int fn, output int kind,
                                     output int alu, output int shamt_a, output int zext);
        kind = K_ILL; alu = 2; shamt_a = 0; zext = 0;
        if (op == 0) begin
            for (int i = 0; i < 14; i++)
                if (r_f[i] == fn) begin kind = K_R; alu = r_c[i]; shamt_a = (fn < 8) ? 1 : 0; end
        end else if (op == 35) kind = K_LW;
        else if (op == 43) kind = K_SW;
        else if (op == 4)  kind = K_BEQ;
        else if (op == 5)  kind = K_BNE;
        else if (op == 2)  kind = K_J;
        else begin
            for (int i = 0; i < 6; i++)
                if (i_op[i] == op) begin kind = K_I; alu = i_c[i]; zext = (op >= 12) ? 1 : 0; end
        end
    endfunction

    // f = FETCH wait cycles, m = MEM_RD/MEM_WR wait cycles.
    function automatic summ_t model(input int op, input int fn, input int z, input int f, input int m);
        summ_t e;
        int kind, alu, sh, zx;
        classify(op, fn, kind, alu, sh, zx);
        e = '{kind: kind, total: 0, alu2: 2, srca2: 0, srcb2: 0, ext2: 0, pcsrc2: 0,
              pcw: 0, regw: 0, rdst: 0, m2r: 0, memr: 0, memw: 0, iordc: 0, irw: 0,
              done: 1, ill: 0};
        case (kind)
            K_R:  begin e.total = f + 4; e.alu2 = alu; e.srca2 = sh ? 2 : 1; e.regw = 1; e.rdst = 1; end
            K_I:  begin e.total = f + 4; e.alu2 = alu; e.srca2 = 1; e.srcb2 = 2; e.ext2 = zx; e.regw = 1; end
            K_LW: begin e.total = f + 5 + m; e.srca2 = 1; e.srcb2 = 2; e.regw = 1; e.m2r = 1; e.memr = m + 1; end
            K_SW: begin e.total = f + 4 + m; e.srca2 = 1; e.srcb2 = 2; e.memw = m + 1; end
            K_BEQ, K_BNE: begin
                e.total = f + 3; e.alu2 = 6; e.srca2 = 1; e.pcsrc2 = 1;
                e.pcw = (kind == K_BEQ) ? z : 1 - z;
            end
            K_J:  begin e.total = f + 3; e.pcsrc2 = 2; e.pcw = 1; end
            default: begin e.total = f + 3; e.done = 0; e.ill = 1; end
        endcase
        e.iordc = e.memr + e.memw;
        return e;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the edge ending the instruction.
    task automatic run_instr(input string nm, input int op, input int fn, input int z,
                             input int f, input int m);
        summ_t e;
        int mr;
        logic [5:0] rnd;
        e = model(op, fn, z, f, m);
        sb.push_back(e);
        sb_nm.push_back(nm);
        for (int c = 0; c < e.total; c++) begin
            mr = $urandom_range(0, 1);
            if (c < f) mr = 0;
            if (c == f) mr = 1;
            if (e.kind == K_LW || e.kind == K_SW) begin
                if (c >= f + 3 && c < f + 3 + m) mr = 0;
                if (c == f + 3 + m) mr = 1;
            end
            mem_ready = mr[0];
            if (c <= f + 1) begin
                opcode = op[5:0];
                funct  = fn[5:0];
            end else begin
                rnd = 6'($urandom); opcode = rnd;
                rnd = 6'($urandom); funct  = rnd;
            end
            Zero = (c == f + 2) ? z[0] : 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Monitor: summarise the current instruction, compare when it retires.
    summ_t o;
    int cyc = 0;
    int k = -1;

    function automatic summ_t blank();
        summ_t b;
        b = '{kind: 0, total: 0, alu2: 0, srca2: 0, srcb2: 0, ext2: 0, pcsrc2: 0,
              pcw: 0, regw: 0, rdst: 0, m2r: 0, memr: 0, memw: 0, iordc: 0, irw: 0,
              done: 0, ill: 0};
        return b;
    endfunction

    always @(negedge clk) begin
        summ_t e;
        string nm;
        if (!rst_n) begin
            cyc = 0; k = -1; o = blank();
        end else begin
            cyc++;
            if (k < 0) begin
                check("fetch.mem_read", mem_read, 1);
                check("fetch.srcB", alu_srcB_sel, 1);
                check("fetch.alu", alu_control, 2);
                check("fetch.iord_srcA_pcsrc", {iord, alu_srcA_sel, pc_src}, 0);
                check("fetch.pc_write", pc_write, mem_ready);
                check("fetch.ir_write", ir_write, mem_ready);
                if (ir_write) k = 0;
            end else begin
                k++;
                if (k == 1) begin
                    check("decode.srcA", alu_srcA_sel, 0);
                    check("decode.srcB", alu_srcB_sel, 3);
                    check("decode.alu", alu_control, 2);
                end
                if (k == 2) begin
                    o.alu2 = alu_control; o.srca2 = alu_srcA_sel; o.srcb2 = alu_srcB_sel;
                    o.ext2 = ext_zero;    o.pcsrc2 = pc_src;
                end
                if (reg_write) begin o.regw++; o.rdst = reg_dst; o.m2r = mem_to_reg; end
                o.memr  += mem_read;
                o.memw  += mem_write;
                o.iordc += iord;
                o.pcw   += pc_write;
                o.irw   += ir_write;
            end
            o.done += instr_done;
            o.ill  += illegal_instr;
            if (instr_done || illegal_instr) begin
                if (sb.size() == 0) begin
                    check("unexpected_retire", 1, 0);
                end else begin
                    e = sb.pop_front();
                    nm = sb_nm.pop_front();
                    check({nm, ".cycles"}, cyc, e.total);
                    check({nm, ".alu"}, o.alu2, e.alu2);
                    check({nm, ".srcA"}, o.srca2, e.srca2);
                    check({nm, ".srcB"}, o.srcb2, e.srcb2);
                    check({nm, ".ext_zero"}, o.ext2, e.ext2);
                    check({nm, ".pc_src"}, o.pcsrc2, e.pcsrc2);
                    check({nm, ".pc_write"}, o.pcw, e.pcw);
                    check({nm, ".reg_write"}, o.regw, e.regw);
                    check({nm, ".reg_dst"}, o.rdst, e.rdst);
                    check({nm, ".mem_to_reg"}, o.m2r, e.m2r);
                    check({nm, ".mem_read"}, o.memr, e.memr);
                    check({nm, ".mem_write"}, o.memw, e.memw);
                    check({nm, ".iord"}, o.iordc, e.iordc);
                    check({nm, ".ir_write"}, o.irw, e.irw);
                    check({nm, ".instr_done"}, o.done, e.done);
                    check({nm, ".illegal"}, o.ill, e.ill);
                end
                cyc = 0; k = -1; o = blank();
            end else if (cyc > 40) begin
                check("retire_timeout", cyc, 0);
                cyc = 0; k = -1; o = blank();
            end
        end
    end

    task automatic check_strobes_off(input string nm);
        check(nm, {mem_read, mem_write, ir_write, pc_write, reg_write, illegal_instr, instr_done}, 0);
    endtask

    initial begin
        int op, fn, kind, alu, sh, zx, sel, f, m;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
            @(negedge clk);
            check_strobes_off("reset.strobes");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr("add",      0, 32, 0, 0, 0);
        run_instr("sra",      0, 3,  0, 0, 0);
        run_instr("rol",      0, 7,  1, 0, 0);
        run_instr("lw_stall", 35, 9, 0, 0, 3);
        run_instr("beq_z1",   4, 0,  1, 0, 0);
        run_instr("beq_z0",   4, 0,  0, 0, 0);
        run_instr("bne_z0",   5, 0,  0, 0, 0);
        run_instr("ill_op",   63, 0, 0, 0, 0);
        run_instr("ill_fn",   0, 8,  0, 0, 0);
        run_instr("sw_stall", 43, 1, 0, 2, 2);
        run_instr("j",        2, 5,  0, 0, 0);
        run_instr("ori",      13, 0, 0, 1, 0);

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 5);
            fn = $urandom_range(0, 63);
            case (sel)
                0: begin op = 0; fn = r_f[$urandom_range(0, 13)]; end
                1: op = i_op[$urandom_range(0, 5)];
                2: op = ($urandom_range(0, 1) == 1) ? 35 : 43;
                3: op = ($urandom_range(0, 1) == 1) ? 4 : 5;
                4: op = 2;
                default: begin
                    do begin
                        op = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 63);
                        fn = $urandom_range(0, 63);
                        classify(op, fn, kind, alu, sh, zx);
                    end while (kind != K_ILL);
                end
            endcase
            f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            m = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            run_instr($sformatf("rnd%0d", n), op, fn, $urandom_range(0, 1), f, m);
        end

        // Abort a lw while it is waiting in MEM_RD.
        opcode = 6'd35; funct = '0; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        check("midreset.mem_read_before", mem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        check_strobes_off("midreset.strobes");
        check("midreset.fetch_srcB", alu_srcB_sel, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr("add_after_reset", 0, 34, 0, 0, 0);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending, expected 0", sb.size());
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
